// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Program-counter controller for the processor front end. Owns the fetch
// address, applies redirects (branch restart, CALL, RET), keeps a hardware
// return-address stack, opens a fixed-length flush window after each redirect
// and halts the core on QUIT or on a RET with an empty stack.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   start_i          leave IDLE and begin fetching at address 0
//   stall_i          hold PC (back-pressure from fetch/decode)
//   restart_i        resolved taken redirect from branch logic
//   restart_addr_i   redirect target
//   op_valid_i       decode-stage opcode valid
//   op_i             decode-stage opcode (QUIT / CALL / RET recognised)
//   op_addr_i        address of the decoded instruction
//   call_target_i    CALL target address
//   pc_o             current fetch address
//   fetch_en_o       fetch request this cycle
//   flush_o          kill younger in-flight instructions
//   halted_o         core halted
//   ras_depth_o      return-address stack occupancy
//   ras_overflow_o   sticky: CALL while stack full
//   ras_underflow_o  sticky: RET while stack empty

module fetch_sequencer #(
    parameter int unsigned IA_WIDTH     = 12,
    parameter int unsigned RAS_DEPTH    = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         stall_i,
    input  logic                         restart_i,
    input  logic [IA_WIDTH-1:0]          restart_addr_i,
    input  logic                         op_valid_i,
    input  logic [6:0]                   op_i,
    input  logic [IA_WIDTH-1:0]          op_addr_i,
    input  logic [IA_WIDTH-1:0]          call_target_i,
    output logic [IA_WIDTH-1:0]          pc_o,
    output logic                         fetch_en_o,
    output logic                         flush_o,
    output logic                         halted_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_depth_o,
    output logic                         ras_overflow_o,
    output logic                         ras_underflow_o
);

    localparam int unsigned PtrW   = $clog2(RAS_DEPTH);
    localparam int unsigned DepthW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(FLUSH_CYCLES + 1);

    localparam logic [6:0] OpQuit = 7'b1111000;
    localparam logic [6:0] OpCall = 7'b1111011;
    localparam logic [6:0] OpRet  = 7'b1111100;

    localparam logic [DepthW-1:0] DepthFull  = DepthW'(RAS_DEPTH);
    localparam logic [CntW-1:0]   FlushLoad  = CntW'(FLUSH_CYCLES);
    localparam logic [CntW-1:0]   CntOne     = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StHalt
    } state_e;

    state_e                state_q;
    logic [IA_WIDTH-1:0]   pc_q;
    logic [CntW-1:0]       cnt_q;
    logic [DepthW-1:0]     depth_q;
    logic [IA_WIDTH-1:0]   stack_q [RAS_DEPTH];
    logic                  overflow_q;
    logic                  underflow_q;

    // Decode-stage opcode classification
    logic is_call, is_ret, is_quit;
    assign is_call = op_valid_i && (op_i == OpCall);
    assign is_ret  = op_valid_i && (op_i == OpRet);
    assign is_quit = op_valid_i && (op_i == OpQuit);

    logic                  stack_full, stack_empty;
    logic [DepthW-1:0]     depth_inc, depth_dec;
    logic [PtrW-1:0]       push_idx, pop_idx;
    logic [IA_WIDTH-1:0]   ret_addr, pc_inc;

    assign stack_full  = (depth_q == DepthFull);
    assign stack_empty = (depth_q == '0);
    assign depth_inc   = depth_q + DepthW'(1);
    assign depth_dec   = depth_q - DepthW'(1);
    // Push index is only used when not full, so depth fits in PtrW bits.
    assign push_idx    = depth_q[PtrW-1:0];
    assign pop_idx     = depth_dec[PtrW-1:0];
    assign ret_addr    = op_addr_i + IA_WIDTH'(1);
    assign pc_inc      = pc_q + IA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            cnt_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        pc_q    <= '0;
                    end
                end

                StRun: begin
                    if (restart_i) begin
                        // Any decode op in this cycle is younger than the branch: drop it.
                        pc_q    <= restart_addr_i;
                        cnt_q   <= FlushLoad;
                        state_q <= StFlush;
                    end else if (is_call) begin
                        if (stack_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            stack_q[push_idx] <= ret_addr;
                            depth_q           <= depth_inc;
                        end
                        pc_q    <= call_target_i;
                        cnt_q   <= FlushLoad;
                        state_q <= StFlush;
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            // No valid return target: stop rather than fetch garbage.
                            underflow_q <= 1'b1;
                            state_q     <= StHalt;
                        end else begin
                            depth_q <= depth_dec;
                            pc_q    <= stack_q[pop_idx];
                            cnt_q   <= FlushLoad;
                            state_q <= StFlush;
                        end
                    end else if (is_quit) begin
                        state_q <= StHalt;
                    end else if (!stall_i) begin
                        pc_q <= pc_inc;
                    end
                end

                StFlush: begin
                    if (restart_i) begin
                        pc_q  <= restart_addr_i;
                        cnt_q <= FlushLoad;
                    end else begin
                        if (!stall_i) begin
                            pc_q <= pc_inc;
                        end
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CntOne;
                        end
                        // Leave as the counter reaches zero so flush_o spans exactly
                        // FLUSH_CYCLES cycles.
                        if (cnt_q <= CntOne) begin
                            state_q <= StRun;
                        end
                    end
                end

                StHalt: begin
                    // Frozen until reset.
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pc_o            = pc_q;
    assign fetch_en_o      = ((state_q == StRun) || (state_q == StFlush)) && !stall_i;
    assign flush_o         = (state_q == StFlush) && (cnt_q != '0);
    assign halted_o        = (state_q == StHalt);
    assign ras_depth_o     = depth_q;
    assign ras_overflow_o  = overflow_q;
    assign ras_underflow_o = underflow_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [6:0] OP_QUIT = 7'b1111000;
    localparam logic [6:0] OP_CALL = 7'b1111011;
    localparam logic [6:0] OP_RET  = 7'b1111100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        stall_i;
    logic        restart_i;
    logic [11:0] restart_addr_i;
    logic        op_valid_i;
    logic [6:0]  op_i;
    logic [11:0] op_addr_i;
    logic [11:0] call_target_i;
    logic [11:0] pc_o;
    logic        fetch_en_o;
    logic        flush_o;
    logic        halted_o;
    logic [3:0]  ras_depth_o;
    logic        ras_overflow_o;
    logic        ras_underflow_o;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(
        .IA_WIDTH    (12),
        .RAS_DEPTH   (8),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .stall_i        (stall_i),
        .restart_i      (restart_i),
        .restart_addr_i (restart_addr_i),
        .op_valid_i     (op_valid_i),
        .op_i           (op_i),
        .op_addr_i      (op_addr_i),
        .call_target_i  (call_target_i),
        .pc_o           (pc_o),
        .fetch_en_o     (fetch_en_o),
        .flush_o        (flush_o),
        .halted_o       (halted_o),
        .ras_depth_o    (ras_depth_o),
        .ras_overflow_o (ras_overflow_o),
        .ras_underflow_o(ras_underflow_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; stall_i = 0; restart_i = 0; restart_addr_i = '0;
        op_valid_i = 0; op_i = '0; op_addr_i = '0; call_target_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic do_start();
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        do_reset();
        outs = {pc_o, fetch_en_o, flush_o, halted_o, ras_depth_o, ras_overflow_o, ras_underflow_o};
        total++;
        if (outs !== 23'd0) begin
            bad++; $display("FAIL reset_outputs got=%0h want=0", outs);
        end
        // restart in IDLE is ignored
        restart_i = 1; restart_addr_i = 12'h555;
        tick();
        restart_i = 0;
        total++;
        if (pc_o !== 12'h000 || fetch_en_o !== 1'b0) begin
            bad++; $display("FAIL idle_restart got pc=%0h fe=%0b want pc=0 fe=0", pc_o, fetch_en_o);
        end
    endtask

    task automatic test_start_stall();
        do_start();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc_o !== 12'(i) || fetch_en_o !== 1'b1) begin
                bad++; $display("FAIL start_seq got pc=%0h fe=%0b want pc=%0h fe=1", pc_o, fetch_en_o, i);
            end
            if (i < 3) tick();
        end
        stall_i = 1;
        #1;
        total++;
        if (fetch_en_o !== 1'b0) begin
            bad++; $display("FAIL stall_fetch_en got=%0b want=0", fetch_en_o);
        end
        tick();
        tick();
        total++;
        if (pc_o !== 12'h003) begin
            bad++; $display("FAIL stall_hold got=%0h want=3", pc_o);
        end
        stall_i = 0;
        tick();
        total++;
        if (pc_o !== 12'h004 || fetch_en_o !== 1'b1) begin
            bad++; $display("FAIL stall_resume got pc=%0h fe=%0b want pc=4 fe=1", pc_o, fetch_en_o);
        end
    endtask

    task automatic test_restart();
        int n;
        do_reset();
        do_start();
        n = 0;
        while (pc_o !== 12'h010 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (pc_o !== 12'h010) begin
            bad++; $display("FAIL reach_pc10 got=%0h want=10", pc_o);
        end
        // restart with a simultaneous CALL: CALL must be discarded
        restart_i = 1; restart_addr_i = 12'h0A0;
        op_valid_i = 1; op_i = OP_CALL; op_addr_i = 12'h050; call_target_i = 12'h300;
        tick();
        idle_inputs();
        total++;
        if (pc_o !== 12'h0A0 || flush_o !== 1'b1 || ras_depth_o !== 4'd0) begin
            bad++; $display("FAIL restart_first got pc=%0h fl=%0b d=%0d want pc=a0 fl=1 d=0",
                            pc_o, flush_o, ras_depth_o);
        end
        tick();
        total++;
        if (pc_o !== 12'h0A1 || flush_o !== 1'b1) begin
            bad++; $display("FAIL restart_second got pc=%0h fl=%0b want pc=a1 fl=1", pc_o, flush_o);
        end
        tick();
        total++;
        if (pc_o !== 12'h0A2 || flush_o !== 1'b0) begin
            bad++; $display("FAIL restart_end got pc=%0h fl=%0b want pc=a2 fl=0", pc_o, flush_o);
        end
        // flush extension by a second restart
        restart_i = 1; restart_addr_i = 12'h0A0;
        tick();
        restart_addr_i = 12'h0C0;
        tick();
        restart_i = 0;
        total++;
        if (pc_o !== 12'h0C0 || flush_o !== 1'b1) begin
            bad++; $display("FAIL extend_first got pc=%0h fl=%0b want pc=c0 fl=1", pc_o, flush_o);
        end
        // CALL during flush is ignored
        op_valid_i = 1; op_i = OP_CALL; op_addr_i = 12'h0C0; call_target_i = 12'h700;
        tick();
        idle_inputs();
        total++;
        if (pc_o !== 12'h0C1 || flush_o !== 1'b1 || ras_depth_o !== 4'd0) begin
            bad++; $display("FAIL extend_second got pc=%0h fl=%0b d=%0d want pc=c1 fl=1 d=0",
                            pc_o, flush_o, ras_depth_o);
        end
        tick();
        total++;
        if (pc_o !== 12'h0C2 || flush_o !== 1'b0) begin
            bad++; $display("FAIL extend_end got pc=%0h fl=%0b want pc=c2 fl=0", pc_o, flush_o);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        do_start();
        op_valid_i = 1; op_i = OP_CALL; op_addr_i = 12'h020; call_target_i = 12'h100;
        tick();
        idle_inputs();
        total++;
        if (pc_o !== 12'h100 || ras_depth_o !== 4'd1 || flush_o !== 1'b1) begin
            bad++; $display("FAIL call got pc=%0h d=%0d fl=%0b want pc=100 d=1 fl=1",
                            pc_o, ras_depth_o, flush_o);
        end
        tick();
        tick();
        op_valid_i = 1; op_i = OP_RET;
        tick();
        idle_inputs();
        total++;
        if (pc_o !== 12'h021 || ras_depth_o !== 4'd0 || flush_o !== 1'b1) begin
            bad++; $display("FAIL ret got pc=%0h d=%0d fl=%0b want pc=21 d=0 fl=1",
                            pc_o, ras_depth_o, flush_o);
        end
        tick();
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        do_start();
        for (int k = 0; k < 9; k++) begin
            op_valid_i = 1; op_i = OP_CALL;
            op_addr_i = 12'h200 + 12'(k * 16); call_target_i = 12'h400 + 12'(k * 16);
            tick();
            idle_inputs();
            if (k == 7) begin
                total++;
                if (ras_overflow_o !== 1'b0 || ras_depth_o !== 4'd8) begin
                    bad++; $display("FAIL full_no_ovf got ovf=%0b d=%0d want ovf=0 d=8",
                                    ras_overflow_o, ras_depth_o);
                end
            end
            if (k == 8) begin
                total++;
                if (ras_overflow_o !== 1'b1 || ras_depth_o !== 4'd8 || pc_o !== 12'h480) begin
                    bad++; $display("FAIL overflow got ovf=%0b d=%0d pc=%0h want ovf=1 d=8 pc=480",
                                    ras_overflow_o, ras_depth_o, pc_o);
                end
            end
            tick();
            tick();
        end
        for (int k = 7; k >= 0; k--) begin
            op_valid_i = 1; op_i = OP_RET;
            tick();
            idle_inputs();
            total++;
            if (pc_o !== 12'h201 + 12'(k * 16) || ras_depth_o !== 4'(k)) begin
                bad++; $display("FAIL lifo_ret got pc=%0h d=%0d want pc=%0h d=%0d",
                                pc_o, ras_depth_o, 12'h201 + 12'(k * 16), k);
            end
            tick();
            tick();
        end
        total++;
        if (ras_overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky got=%0b want=1", ras_overflow_o);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        do_start();
        tick();
        tick();
        op_valid_i = 1; op_i = OP_RET;
        tick();
        idle_inputs();
        total++;
        if (ras_underflow_o !== 1'b1 || halted_o !== 1'b1 || fetch_en_o !== 1'b0 ||
            pc_o !== 12'h002 || flush_o !== 1'b0) begin
            bad++; $display("FAIL underflow got unf=%0b h=%0b fe=%0b pc=%0h fl=%0b want 1 1 0 2 0",
                            ras_underflow_o, halted_o, fetch_en_o, pc_o, flush_o);
        end
        restart_i = 1; restart_addr_i = 12'h333; start_i = 1;
        tick();
        tick();
        idle_inputs();
        total++;
        if (pc_o !== 12'h002 || halted_o !== 1'b1) begin
            bad++; $display("FAIL underflow_frozen got pc=%0h h=%0b want pc=2 h=1", pc_o, halted_o);
        end
    endtask

    task automatic test_quit();
        do_reset();
        total++;
        if (ras_underflow_o !== 1'b0 || halted_o !== 1'b0) begin
            bad++; $display("FAIL reset_clears got unf=%0b h=%0b want 0 0", ras_underflow_o, halted_o);
        end
        do_start();
        tick();
        op_valid_i = 1; op_i = OP_QUIT;
        tick();
        idle_inputs();
        total++;
        if (halted_o !== 1'b1 || pc_o !== 12'h001 || flush_o !== 1'b0 || fetch_en_o !== 1'b0) begin
            bad++; $display("FAIL quit got h=%0b pc=%0h fl=%0b fe=%0b want 1 1 0 0",
                            halted_o, pc_o, flush_o, fetch_en_o);
        end
        restart_i = 1; restart_addr_i = 12'h444; start_i = 1;
        tick();
        tick();
        tick();
        idle_inputs();
        total++;
        if (halted_o !== 1'b1 || pc_o !== 12'h001) begin
            bad++; $display("FAIL quit_frozen got h=%0b pc=%0h want h=1 pc=1", halted_o, pc_o);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_pc [4];
        exp_pc[0] = 12'hFFE; exp_pc[1] = 12'hFFF; exp_pc[2] = 12'h000; exp_pc[3] = 12'h001;
        do_reset();
        do_start();
        restart_i = 1; restart_addr_i = 12'hFFE;
        tick();
        restart_i = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc_o !== exp_pc[i]) begin
                bad++; $display("FAIL wrap got=%0h want=%0h", pc_o, exp_pc[i]);
            end
            if (i < 3) tick();
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_start_stall();
        test_restart();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_quit();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
